// File: rtl/memarb_pkg.sv
// ---------------------------------------------------------------------------
// memarb_pkg
// Shared types and constants for the main-memory arbiter slice.
//   state_t : arbiter FSM states (idle / I-side burst / D-side access / done)
//   owner_t : which requester currently owns, or last owned, the memory port
//   WORD_W, BE_W        : memory word width and byte-enable width
//   DEFAULT_LINE_WORDS  : default number of words per I-cache line
// Optional build macro used by the importing files: MEMARB_RR_EN.
// ---------------------------------------------------------------------------
package memarb_pkg;

   localparam int WORD_W             = 32;
   localparam int BE_W               = 4;
   localparam int DEFAULT_LINE_WORDS = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_IBURST = 2'd1,
      ST_DACC   = 2'd2,
      ST_FIN    = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant selection between the I-side refill request and the
// D-side load/store request.
//   iIREQ  : I-side request level
//   iDREQ  : D-side request level
//   iLAST  : owner of the previous grant (present only with MEMARB_RR_EN)
//   oGNT   : some request is pending and will be granted
//   oOWNER : side that receives the grant
// Build macro MEMARB_RR_EN: defined -> round-robin on ties (the side not
// granted last wins); undefined -> fixed priority, D-side wins ties.
// ---------------------------------------------------------------------------
module mem_arb_pick
   import memarb_pkg::*;
(
   input  logic   iIREQ,
   input  logic   iDREQ,
`ifdef MEMARB_RR_EN
   input  owner_t iLAST,
`endif
   output logic   oGNT,
   output owner_t oOWNER
);

   // A single requester always wins; only the tie case depends on the policy.
   always_comb begin
      oGNT   = iIREQ | iDREQ;
      oOWNER = OWN_D;
      if (iIREQ && iDREQ) begin
`ifdef MEMARB_RR_EN
         oOWNER = (iLAST == OWN_D) ? OWN_I : OWN_D;
`else
         oOWNER = OWN_D;
`endif
      end else if (iIREQ) begin
         oOWNER = OWN_I;
      end
   end

endmodule

// File: rtl/mem_arbiter_rv32.sv
// ---------------------------------------------------------------------------
// mem_arbiter_rv32
// Shares the single main-memory port between the I-cache refill path and the
// D-side load/store path. I-side grants run a LINE_WORDS-beat read burst in
// index order 0..LINE_WORDS-1; D-side grants run one read or write beat.
// Ports:
//   iCLK, iRST                 : clock, synchronous active-high reset
//   iIREQ, iIADDR              : I-side refill request and miss address
//   oIDATA, oIVALID, oIWIDX    : refill word, its valid strobe, word index
//   oIDONE                     : one-cycle refill-complete pulse
//   iDREQ, iDWE, iDADDR,
//   iDWDATA, iDBE              : D-side request, write flag, address, data, BE
//   oDRDATA, oDDONE            : D-side read data and completion pulse
//   oMREQ, oMWE, oMADDR,
//   oMWDATA, oMBE              : memory beat request and its attributes
//   iMACK, iMRDATA             : memory beat accept and same-cycle read data
// Build macro MEMARB_RR_EN: enables round-robin tie breaking and the
// last-grant register; without it the D-side always wins ties.
// ---------------------------------------------------------------------------
module mem_arbiter_rv32
   import memarb_pkg::*;
#(
   parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
   parameter int ADDR_W     = 32
)(
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic                          iIREQ,
   input  logic [ADDR_W-1:0]             iIADDR,
   output logic [WORD_W-1:0]             oIDATA,
   output logic                          oIVALID,
   output logic [$clog2(LINE_WORDS)-1:0] oIWIDX,
   output logic                          oIDONE,
   input  logic                          iDREQ,
   input  logic                          iDWE,
   input  logic [ADDR_W-1:0]             iDADDR,
   input  logic [WORD_W-1:0]             iDWDATA,
   input  logic [BE_W-1:0]               iDBE,
   output logic [WORD_W-1:0]             oDRDATA,
   output logic                          oDDONE,
   output logic                          oMREQ,
   output logic                          oMWE,
   output logic [ADDR_W-1:0]             oMADDR,
   output logic [WORD_W-1:0]             oMWDATA,
   output logic [BE_W-1:0]               oMBE,
   input  logic                          iMACK,
   input  logic [WORD_W-1:0]             iMRDATA
);

   localparam int                IDX_W    = $clog2(LINE_WORDS);
   localparam int                OFF_W    = IDX_W + 2;
   localparam int                BASE_W   = ADDR_W - OFF_W;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

   state_t              r_state,  w_stateNext;
   logic [IDX_W-1:0]    r_idx,    w_idxNext;
   logic [BASE_W-1:0]   r_lbase,  w_lbaseNext;
   logic                r_mreq,   w_mreqNext;
   logic                r_mwe,    w_mweNext;
   logic [ADDR_W-1:0]   r_maddr,  w_maddrNext;
   logic [WORD_W-1:0]   r_mwdata, w_mwdataNext;
   logic [BE_W-1:0]     r_mbe,    w_mbeNext;
   logic [WORD_W-1:0]   r_idata,  w_idataNext;
   logic [IDX_W-1:0]    r_iwidx,  w_iwidxNext;
   logic                r_ivalid, w_ivalidNext;
   logic                r_idone,  w_idoneNext;
   logic [WORD_W-1:0]   r_drdata, w_drdataNext;
   logic                r_ddone,  w_ddoneNext;
   logic                w_gnt;
   owner_t              w_owner;
   logic                w_unused;
`ifdef MEMARB_RR_EN
   owner_t              r_lastGrant, w_lastGrantNext;
`endif

   // Line-offset bits of the miss address and byte bits of the D address
   // are deliberately dropped; the memory side only sees word addresses.
   assign w_unused = ^{iIADDR[OFF_W-1:0], iDADDR[1:0]};

   mem_arb_pick u_pick (
      .iIREQ  (iIREQ),
      .iDREQ  (iDREQ),
`ifdef MEMARB_RR_EN
      .iLAST  (r_lastGrant),
`endif
      .oGNT   (w_gnt),
      .oOWNER (w_owner)
   );

   // Next-state and next-output logic. Every memory-side output is computed
   // here one cycle ahead so that all ports come straight from flops. The
   // valid/done strobes default low so each one lasts exactly one cycle.
   always_comb begin
      w_stateNext  = r_state;
      w_idxNext    = r_idx;
      w_lbaseNext  = r_lbase;
      w_mreqNext   = r_mreq;
      w_mweNext    = r_mwe;
      w_maddrNext  = r_maddr;
      w_mwdataNext = r_mwdata;
      w_mbeNext    = r_mbe;
      w_idataNext  = r_idata;
      w_iwidxNext  = r_iwidx;
      w_ivalidNext = 1'b0;
      w_idoneNext  = 1'b0;
      w_drdataNext = r_drdata;
      w_ddoneNext  = 1'b0;
`ifdef MEMARB_RR_EN
      w_lastGrantNext = r_lastGrant;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_gnt) begin
`ifdef MEMARB_RR_EN
               w_lastGrantNext = w_owner;
`endif
               w_mreqNext = 1'b1;
               w_idxNext  = '0;
               if (w_owner == OWN_I) begin
                  w_stateNext = ST_IBURST;
                  w_lbaseNext = iIADDR[ADDR_W-1:OFF_W];
                  w_maddrNext = {iIADDR[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  w_mweNext   = 1'b0;
                  w_mbeNext   = '1;
               end else begin
                  w_stateNext  = ST_DACC;
                  w_maddrNext  = {iDADDR[ADDR_W-1:2], 2'b00};
                  w_mweNext    = iDWE;
                  w_mwdataNext = iDWDATA;
                  w_mbeNext    = iDWE ? iDBE : '1;
               end
            end
         end
         // The burst address is rebuilt from the latched line base so the
         // index never carries into the line base.
         ST_IBURST: begin
            if (iMACK) begin
               w_idataNext  = iMRDATA;
               w_iwidxNext  = r_idx;
               w_ivalidNext = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_stateNext = ST_FIN;
                  w_mreqNext  = 1'b0;
                  w_idoneNext = 1'b1;
               end else begin
                  w_idxNext   = r_idx + IDX_W'(1);
                  w_maddrNext = {r_lbase, r_idx + IDX_W'(1), 2'b00};
               end
            end
         end
         ST_DACC: begin
            if (iMACK) begin
               if (!r_mwe) begin
                  w_drdataNext = iMRDATA;
               end
               w_ddoneNext = 1'b1;
               w_mreqNext  = 1'b0;
               w_mweNext   = 1'b0;
               w_stateNext = ST_FIN;
            end
         end
         // Done pulse is already on the port this cycle; requests and acks
         // are ignored so the owner has time to drop its request.
         ST_FIN: begin
            w_stateNext = ST_IDLE;
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   // without producing a done pulse.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_lbase  <= '0;
         r_mreq   <= 1'b0;
         r_mwe    <= 1'b0;
         r_maddr  <= '0;
         r_mwdata <= '0;
         r_mbe    <= '0;
         r_idata  <= '0;
         r_iwidx  <= '0;
         r_ivalid <= 1'b0;
         r_idone  <= 1'b0;
         r_drdata <= '0;
         r_ddone  <= 1'b0;
`ifdef MEMARB_RR_EN
         r_lastGrant <= OWN_D;
`endif
      end else begin
         r_state  <= w_stateNext;
         r_idx    <= w_idxNext;
         r_lbase  <= w_lbaseNext;
         r_mreq   <= w_mreqNext;
         r_mwe    <= w_mweNext;
         r_maddr  <= w_maddrNext;
         r_mwdata <= w_mwdataNext;
         r_mbe    <= w_mbeNext;
         r_idata  <= w_idataNext;
         r_iwidx  <= w_iwidxNext;
         r_ivalid <= w_ivalidNext;
         r_idone  <= w_idoneNext;
         r_drdata <= w_drdataNext;
         r_ddone  <= w_ddoneNext;
`ifdef MEMARB_RR_EN
         r_lastGrant <= w_lastGrantNext;
`endif
      end
   end

   assign oMREQ   = r_mreq;
   assign oMWE    = r_mwe;
   assign oMADDR  = r_maddr;
   assign oMWDATA = r_mwdata;
   assign oMBE    = r_mbe;
   assign oIDATA  = r_idata;
   assign oIWIDX  = r_iwidx;
   assign oIVALID = r_ivalid;
   assign oIDONE  = r_idone;
   assign oDRDATA = r_drdata;
   assign oDDONE  = r_ddone;

endmodule

// File: tb/tb_mem_arbiter_rv32.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_rv32
// Self-checking bench for mem_arbiter_rv32 (LINE_WORDS=4, ADDR_W=32).
// Expected memory beats and returned data are queued when a request is
// driven and popped when the arbiter issues the beat / returns the word.
// Honors MEMARB_RR_EN for the expected tie-break order.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_rv32;

   logic        iCLK;
   logic        iRST;
   logic        iIREQ;
   logic [31:0] iIADDR;
   logic [31:0] oIDATA;
   logic        oIVALID;
   logic [1:0]  oIWIDX;
   logic        oIDONE;
   logic        iDREQ;
   logic        iDWE;
   logic [31:0] iDADDR;
   logic [31:0] iDWDATA;
   logic [3:0]  iDBE;
   logic [31:0] oDRDATA;
   logic        oDDONE;
   logic        oMREQ;
   logic        oMWE;
   logic [31:0] oMADDR;
   logic [31:0] oMWDATA;
   logic [3:0]  oMBE;
   logic        iMACK;
   logic [31:0] iMRDATA;

   typedef struct packed {
      logic [1:0]  widx;
      logic [31:0] data;
   } rd_t;

   int          vectors;
   int          miscompares;
   logic [31:0] addrQ[$];
   rd_t         dataQ[$];
   logic        ownQ[$];

   mem_arbiter_rv32 #(.LINE_WORDS(4), .ADDR_W(32)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iIREQ   (iIREQ),
      .iIADDR  (iIADDR),
      .oIDATA  (oIDATA),
      .oIVALID (oIVALID),
      .oIWIDX  (oIWIDX),
      .oIDONE  (oIDONE),
      .iDREQ   (iDREQ),
      .iDWE    (iDWE),
      .iDADDR  (iDADDR),
      .iDWDATA (iDWDATA),
      .iDBE    (iDBE),
      .oDRDATA (oDRDATA),
      .oDDONE  (oDDONE),
      .oMREQ   (oMREQ),
      .oMWE    (oMWE),
      .oMADDR  (oMADDR),
      .oMWDATA (oMWDATA),
      .oMBE    (oMBE),
      .iMACK   (iMACK),
      .iMRDATA (iMRDATA)
   );

   // Memory contents are a fixed scramble of the word address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign iMRDATA = memWord(oMADDR);

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // Hard stop so a hung handshake can never stall the run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic test_reset();
      iRST = 1'b1;
      tick();
      tick();
      vectors++;
      if ({oMREQ, oMWE, oIVALID, oIDONE, oDDONE} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b expected 00000", {oMREQ, oMWE, oIVALID, oIDONE, oDDONE});
      end
      vectors++;
      if ({oMADDR, oMWDATA, oMBE} !== 68'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_mem_bus: got %h/%h/%h expected 0/0/0", oMADDR, oMWDATA, oMBE);
      end
      vectors++;
      if ({oIDATA, oDRDATA, oIWIDX} !== 66'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_return: got %h/%h/%h expected 0/0/0", oIDATA, oDRDATA, oIWIDX);
      end
      iRST = 1'b0;
      tick();
      vectors++;
      if (oMREQ !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle_mreq: got %b expected 0", oMREQ);
      end
   endtask

   // Drives one I-side refill starting in an idle cycle and checks every
   // cycle: beat addresses, refill words, valid/done timing. iMACK is held
   // high except in cycle waitCycle (0 = no wait), so it is also high while
   // the arbiter sits in IDLE and FIN. iIREQ drops in cycle dropCycle.
   task automatic drive_i_burst(input logic [31:0] addr, input int waitCycle, input int dropCycle);
      logic [31:0] base;
      logic [31:0] expAddr;
      rd_t         expRd;
      int          beats;
      logic        pendValid;
      logic        pendDone;
      logic        nextValid;
      logic        nextDone;
      base = addr & 32'hFFFF_FFF0;
      for (int k = 0; k < 4; k++) begin
         addrQ.push_back(base + 32'(4 * k));
         expRd.widx = 2'(k);
         expRd.data = memWord(base + 32'(4 * k));
         dataQ.push_back(expRd);
      end
      iIADDR    = addr;
      iIREQ     = 1'b1;
      iMACK     = 1'b1;
      beats     = 0;
      pendValid = 1'b0;
      pendDone  = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == dropCycle) iIREQ = 1'b0;
         iMACK = (c != waitCycle);
         vectors++;
         if (oIVALID !== pendValid) begin
            miscompares++;
            $display("[TB] FAIL i_valid c%0d: got %b expected %b", c, oIVALID, pendValid);
         end
         if (oIVALID === 1'b1 && pendValid) begin
            vectors++;
            if (dataQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL i_word c%0d: got unexpected word expected none", c);
            end else begin
               expRd = dataQ.pop_front();
               if ({oIWIDX, oIDATA} !== {expRd.widx, expRd.data}) begin
                  miscompares++;
                  $display("[TB] FAIL i_word c%0d: got idx %0d data %h expected idx %0d data %h",
                           c, oIWIDX, oIDATA, expRd.widx, expRd.data);
               end
            end
         end
         vectors++;
         if (oIDONE !== pendDone) begin
            miscompares++;
            $display("[TB] FAIL i_done c%0d: got %b expected %b", c, oIDONE, pendDone);
         end
         vectors++;
         if (oMREQ !== (beats < 4)) begin
            miscompares++;
            $display("[TB] FAIL i_mreq c%0d: got %b expected %b", c, oMREQ, (beats < 4));
         end
         nextValid = 1'b0;
         nextDone  = 1'b0;
         if (oMREQ === 1'b1 && iMACK) begin
            vectors++;
            if (addrQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL i_beat c%0d: got extra beat at %h expected none", c, oMADDR);
            end else begin
               expAddr = addrQ.pop_front();
               if ({oMADDR, oMWE, oMBE} !== {expAddr, 1'b0, 4'hF}) begin
                  miscompares++;
                  $display("[TB] FAIL i_beat c%0d: got addr %h we %b be %h expected addr %h we 0 be f",
                           c, oMADDR, oMWE, oMBE, expAddr);
               end
            end
            beats++;
            nextValid = 1'b1;
            nextDone  = (beats == 4);
         end
         pendValid = nextValid;
         pendDone  = nextDone;
      end
      iMACK = 1'b0;
      iIREQ = 1'b0;
      vectors++;
      if (addrQ.size() != 0 || dataQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL i_complete: got %0d beats/%0d words outstanding expected 0/0", addrQ.size(), dataQ.size());
      end
      addrQ.delete();
      dataQ.delete();
   endtask

   task automatic test_i_refill();
      drive_i_burst(32'h0000_1234, 0, 1);
   endtask

   // Write at 0x102 with two wait states: request held three cycles with
   // stable attributes, done one cycle after the accepting edge.
   task automatic test_d_write();
      logic [31:0] expAddr;
      logic        pend;
      logic        nextPend;
      addrQ.push_back(32'h0000_0100);
      iDREQ   = 1'b1;
      iDWE    = 1'b1;
      iDADDR  = 32'h0000_0102;
      iDWDATA = 32'hCAFE_BABE;
      iDBE    = 4'b0011;
      iMACK   = 1'b0;
      pend    = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) begin
            iDREQ   = 1'b0;
            iDWE    = 1'b0;
            iDWDATA = 32'h0;
            iDBE    = 4'h0;
         end
         iMACK = (c == 3);
         vectors++;
         if (oDDONE !== pend) begin
            miscompares++;
            $display("[TB] FAIL d_wr_done c%0d: got %b expected %b", c, oDDONE, pend);
         end
         vectors++;
         if (oMREQ !== (c <= 3)) begin
            miscompares++;
            $display("[TB] FAIL d_wr_mreq c%0d: got %b expected %b", c, oMREQ, (c <= 3));
         end
         if (oMREQ === 1'b1) begin
            vectors++;
            if ({oMWE, oMBE, oMWDATA} !== {1'b1, 4'b0011, 32'hCAFE_BABE}) begin
               miscompares++;
               $display("[TB] FAIL d_wr_attr c%0d: got we %b be %h data %h expected we 1 be 3 data cafebabe",
                        c, oMWE, oMBE, oMWDATA);
            end
         end
         nextPend = 1'b0;
         if (oMREQ === 1'b1 && iMACK) begin
            nextPend = 1'b1;
            vectors++;
            if (addrQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL d_wr_addr c%0d: got extra beat expected none", c);
            end else begin
               expAddr = addrQ.pop_front();
               if (oMADDR !== expAddr) begin
                  miscompares++;
                  $display("[TB] FAIL d_wr_addr c%0d: got %h expected %h", c, oMADDR, expAddr);
               end
            end
         end
         pend = nextPend;
      end
      iMACK = 1'b0;
      vectors++;
      if (addrQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL d_wr_complete: got %0d beats outstanding expected 0", addrQ.size());
      end
      addrQ.delete();
   endtask

   // Zero-wait read: beat at n+1, data and done at n+2.
   task automatic test_d_read();
      rd_t expRd;
      addrQ.push_back(32'h0000_2004);
      expRd.widx = 2'd0;
      expRd.data = memWord(32'h0000_2004);
      dataQ.push_back(expRd);
      iDREQ  = 1'b1;
      iDWE   = 1'b0;
      iDADDR = 32'h0000_2006;
      iDBE   = 4'h0;
      iMACK  = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) iDREQ = 1'b0;
         vectors++;
         if (oDDONE !== (c == 2)) begin
            miscompares++;
            $display("[TB] FAIL d_rd_done c%0d: got %b expected %b", c, oDDONE, (c == 2));
         end
         if (oDDONE === 1'b1 && dataQ.size() != 0) begin
            expRd = dataQ.pop_front();
            vectors++;
            if (oDRDATA !== expRd.data) begin
               miscompares++;
               $display("[TB] FAIL d_rd_data: got %h expected %h", oDRDATA, expRd.data);
            end
         end
         if (oMREQ === 1'b1 && iMACK && addrQ.size() != 0) begin
            vectors++;
            if ({oMADDR, oMWE, oMBE} !== {addrQ.pop_front(), 1'b0, 4'hF}) begin
               miscompares++;
               $display("[TB] FAIL d_rd_beat c%0d: got addr %h we %b be %h expected addr 00002004 we 0 be f",
                        c, oMADDR, oMWE, oMBE);
            end
         end
      end
      iMACK = 1'b0;
      vectors++;
      if (addrQ.size() != 0 || dataQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL d_rd_complete: got %0d/%0d outstanding expected 0/0", addrQ.size(), dataQ.size());
      end
      addrQ.delete();
      dataQ.delete();
   endtask

   // Both sides request continuously; the owner of each new transaction is
   // identified by its address region (I at 0x4000, D at 0x8000).
   task automatic test_arbitration();
      int   grants;
      logic prevReq;
      logic expD;
      logic gotD;
      iRST = 1'b1;
      tick();
      iRST = 1'b0;
`ifdef MEMARB_RR_EN
      ownQ.push_back(1'b0);
      ownQ.push_back(1'b1);
      ownQ.push_back(1'b0);
      ownQ.push_back(1'b1);
`else
      for (int k = 0; k < 4; k++) ownQ.push_back(1'b1);
`endif
      iIADDR = 32'h0000_4000;
      iDADDR = 32'h0000_8000;
      iDWE   = 1'b0;
      iMACK  = 1'b1;
      iIREQ  = 1'b1;
      iDREQ  = 1'b1;
      grants  = 0;
      prevReq = 1'b0;
      for (int c = 1; c <= 40 && grants < 4; c++) begin
         tick();
         if (oMREQ === 1'b1 && prevReq === 1'b0) begin
            gotD = oMADDR[15];
            expD = ownQ.pop_front();
            grants++;
            vectors++;
            if (gotD !== expD) begin
               miscompares++;
               $display("[TB] FAIL arb_grant%0d: got %s expected %s", grants, gotD ? "D" : "I", expD ? "D" : "I");
            end
         end
         prevReq = oMREQ;
      end
      iIREQ = 1'b0;
      iDREQ = 1'b0;
      vectors++;
      if (grants != 4) begin
         miscompares++;
         $display("[TB] FAIL arb_timeout: got %0d grants expected 4", grants);
      end
      ownQ.delete();
      repeat (8) tick();
      iMACK = 1'b0;
   endtask

   // Acks in IDLE before the request and in FIN/IDLE after it, a wait state
   // on the second beat, and the request dropped mid-burst.
   task automatic test_ignored_inputs();
      iMACK = 1'b1;
      tick();
      tick();
      vectors++;
      if ({oMREQ, oIVALID, oIDONE, oDDONE} !== 4'b0) begin
         miscompares++;
         $display("[TB] FAIL idle_ack: got %b expected 0000", {oMREQ, oIVALID, oIDONE, oDDONE});
      end
      drive_i_burst(32'h0000_ABC8, 2, 2);
   endtask

   // Reset lands on the edge that accepts beat 2; the burst is abandoned
   // and a fresh request must start again at index 0.
   task automatic test_reset_mid();
      iIADDR = 32'h0000_3000;
      iIREQ  = 1'b1;
      iMACK  = 1'b1;
      tick();
      iIREQ = 1'b0;
      vectors++;
      if (oMADDR !== 32'h0000_3000) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_beat1: got %h expected 00003000", oMADDR);
      end
      tick();
      vectors++;
      if (oMADDR !== 32'h0000_3004) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_beat2: got %h expected 00003004", oMADDR);
      end
      iRST = 1'b1;
      tick();
      iRST = 1'b0;
      vectors++;
      if ({oMREQ, oIVALID, oIDONE} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL rst_mid_after: got %b expected 000", {oMREQ, oIVALID, oIDONE});
      end
      for (int c = 0; c < 6; c++) begin
         tick();
         vectors++;
         if ({oMREQ, oIDONE} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_quiet c%0d: got %b expected 00", c, {oMREQ, oIDONE});
         end
      end
      drive_i_burst(32'h0000_3000, 0, 1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      iRST    = 1'b1;
      iIREQ   = 1'b0;
      iIADDR  = 32'h0;
      iDREQ   = 1'b0;
      iDWE    = 1'b0;
      iDADDR  = 32'h0;
      iDWDATA = 32'h0;
      iDBE    = 4'h0;
      iMACK   = 1'b0;
      test_reset();
      test_i_refill();
      test_d_write();
      test_d_read();
      test_arbitration();
      test_ignored_inputs();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_arbiter_rv32.md
# mem_arbiter_rv32

Shares the single main-memory port between the instruction-cache refill path and the data-side load/store path. It grants one requester at a time and runs a LINE_WORDS-beat read burst for I-side refills or a single-beat read/write for D-side accesses. Read data is returned to the owner with per-beat valid and a done pulse. It sits between both caches and the external memory interface, and drives the cache stall/refill sequencing.

## Interface
- LINE_WORDS, 4: words per I-cache line; power of two, ≥2.
- ADDR_W, 32: byte address width.

- iCLK  in  1  clock; all state changes on rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iIREQ  in  1  I-side refill request; level.
- iIADDR  in  ADDR_W  I-side miss address. Low $clog2(LINE_WORDS)+2 bits are ignored.
- oIDATA  out  32  refill word.
- oIVALID  out  1  oIDATA/oIWIDX valid this cycle.
- oIWIDX  out  $clog2(LINE_WORDS)  word index within the line.
- oIDONE  out  1  one-cycle pulse; refill complete.
- iDREQ  in  1  D-side request; level.
- iDWE  in  1  1 = write, 0 = read.
- iDADDR  in  ADDR_W  D-side word address; bits [1:0] are ignored.
- iDWDATA  in  32  write data.
- iDBE  in  4  byte enables for writes.
- oDRDATA  out  32  read data; valid while oDDONE=1.
- oDDONE  out  1  one-cycle pulse; access complete.
- oMREQ  out  1  memory beat request.
- oMWE  out  1  memory write.
- oMADDR  out  ADDR_W  memory byte address, word-aligned.
- oMWDATA  out  32  memory write data.
- oMBE  out  4  memory byte enables; 4'hF on reads.
- iMACK  in  1  beat accepted. Read data is valid in the same cycle.
- iMRDATA  in  32  memory read data.

## Operation
- FSM states:
  - IDLE: grant decision.
  - IBURST: I-side burst in progress.
  - DACC: D-side single access.
  - FIN: done pulse cycle.
- Requests are sampled only in IDLE. Address, iDWE, iDWDATA and iDBE are latched at grant.
- Dropping a request after grant is ignored; the transaction completes.
- IDLE → IBURST or DACC on a granted request, with beat index = 0.
  - Only iIREQ → I is granted.
  - Only iDREQ → D is granted.
  - Both asserted → policy per Configuration.
- IBURST:
  - oMADDR = {latched line base, beat index, 2'b00}.
  - On each iMACK: capture iMRDATA to oIDATA, set oIWIDX = beat index, pulse oIVALID next cycle, increment the index.
  - Burst order is always index 0..LINE_WORDS-1; no critical-word-first and no carry into the line base.
  - On the ack for index LINE_WORDS-1 → FIN.
- DACC: one beat. On iMACK, a read captures iMRDATA into oDRDATA; then → FIN.
- FIN:
  - oIDONE or oDDONE = 1 for exactly one cycle, to the owner only.
  - Requests are ignored in this cycle so the requester can deassert.
  - → IDLE.
- iMACK is ignored in IDLE and FIN.
- oMREQ is 1 only in IBURST/DACC. oMADDR/oMWE/oMWDATA/oMBE are stable while oMREQ=1 and no ack.
- Reset values, all registered:
  - oMREQ, oMWE, oIVALID, oIDONE, oDDONE = 0.
  - oMADDR, oMWDATA, oIDATA, oDRDATA, oIWIDX = 0.
  - oMBE = 0.
  - State = IDLE; last-grant = D.
- Reset mid-transaction:
  - The partial burst or access is abandoned with no done pulse.
  - oMREQ drops the cycle after the reset edge.
  - The requester must re-request.

## Timing
- Request sampled in IDLE in cycle n → oMREQ=1 with the first address in cycle n+1.
- Ack every cycle, I-side: beats in n+1..n+LINE_WORDS; oIVALID in n+2..n+LINE_WORDS+1; oIDONE at n+LINE_WORDS+1, coincident with the last oIVALID; IDLE at n+LINE_WORDS+2.
- Ack every cycle, D-side: beat at n+1, oDDONE at n+2, IDLE at n+3.
- Back-to-back beats: oMREQ stays high and oMADDR advances on the ack edge.
- Wait states: any number of cycles with iMACK=0 stretch the beat with no other effect.

## Configuration
- MEMARB_RR_EN defined: round-robin on simultaneous requests; grant the side not granted last.
  - Last-grant resets to D, so I wins the first tie.
  - Last-grant updates at each grant.
- Undefined: fixed priority, D always wins ties. The last-grant register is not built.

## Structure
- Package memarb_pkg:
  - State enum (IDLE/IBURST/DACC/FIN).
  - Owner enum (I/D).
  - Word width constant 32 and byte-enable width 4.
  - Default LINE_WORDS.
- Sub-module mem_arb_pick: combinational grant selection from iIREQ, iDREQ and last-grant. Contains the MEMARB_RR_EN choice.
- Top module: FSM, beat counter, latches, output registers.

## Test plan
- I-refill, LINE_WORDS=4, iIADDR=0x0000_1234, iMACK=1 always → oMADDR 0x1230,0x1234,0x1238,0x123C; oIWIDX 0..3 with matching data; oIDONE at n+5.
- D write, iDADDR=0x0000_0102, iDBE=4'b0011, wait states 2 → oMADDR=0x100, oMWE=1 held 3 cycles, oDDONE one cycle after the ack.
- Simultaneous iIREQ/iDREQ held high:
  - with MEMARB_RR_EN, grant order is I,D,I,D;
  - without it, D repeats while iDREQ stays high.
- iMACK pulses in IDLE/FIN and iIREQ dropped mid-burst → ignored; the burst completes with 4 beats.
- iRST asserted after beat 2 of a burst → next cycle oMREQ=0, no oIDONE; a fresh request restarts at index 0.
